// File: rtl/bft_host_endpoint.sv
// BFT host endpoint: credit-paced TX packetizer and buffered RX depacketizer.
// Optional RX sequence checking is enabled by defining BFT_HOST_SEQ_CHECK_EN.

// Generic synchronous FIFO with first-word fall-through head.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push_rdy is low only when full and not popping this cycle.
module bft_host_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop_rdy && head_vld;
    assign push_rdy = (count != (AW+1)'(DEPTH)) || do_pop;
    assign do_push  = push_vld && push_rdy;
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Host endpoint terminating the BFT leaf packet protocol.
// Latency: TX accept -> dout_host2bft 1 cycle; RX packet -> vld_host2user 1 cycle.
// Backpressure: TX stalls at zero credits; RX drops data packets on full FIFO.
module bft_host_endpoint #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 3,
    parameter int NUM_PORT_BITS = 4,
    parameter int CREDIT_INIT   = 64,
    parameter int RX_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PACKET_BITS-1:0]   dout_host2bft,
    input  logic [PACKET_BITS-1:0]   din_bft2host,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user2host,
    input  logic                     vld_user2host,
    output logic                     ack_host2user,
    output logic [PAYLOAD_BITS-1:0]  dout_host2user,
    output logic                     vld_host2user,
    input  logic                     ack_user2host,
    output logic [6:0]               credits,
    output logic [7:0]               drop_cnt,
    output logic                     seq_err
);
    localparam int SEQ_LSB  = PAYLOAD_BITS;
    localparam int CTRL_BIT = PAYLOAD_BITS + 8;

    logic                    din_vld;
    logic                    din_ctrl;
    logic [7:0]              din_seq;
    logic [PAYLOAD_BITS-1:0] din_payload;
    logic [7:0]              tx_seq;
    logic                    tx_acc;
    logic [6:0]              credit_inc;
    logic [8:0]              credit_sum;
    logic [6:0]              credits_nxt;
    logic                    rx_data_vld;
    logic                    rx_push_rdy;
    logic                    rx_push_ok;
    logic                    rx_drop;
    logic                    unused_hdr;

    assign din_vld     = din_bft2host[PACKET_BITS-1];
    assign din_ctrl    = din_bft2host[CTRL_BIT];
    assign din_seq     = din_bft2host[SEQ_LSB +: 8];
    assign din_payload = din_bft2host[PAYLOAD_BITS-1:0];
    assign unused_hdr  = ^din_bft2host[PACKET_BITS-2:CTRL_BIT+1];

    // Reset gates ack so nothing is accepted while state is being reloaded.
    assign tx_acc        = vld_user2host && (credits != '0) && !reset;
    assign ack_host2user = tx_acc;

    assign credit_inc  = (din_vld && din_ctrl) ? din_payload[6:0] : '0;
    assign credit_sum  = 9'(credits) + 9'(credit_inc) - 9'(tx_acc);
    assign credits_nxt = (credit_sum > 9'(CREDIT_INIT)) ? 7'(CREDIT_INIT) : credit_sum[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_host2bft <= '0;
            tx_seq        <= '0;
            credits       <= 7'(CREDIT_INIT);
        end else begin
            credits <= credits_nxt;
            if (tx_acc) begin
                dout_host2bft <= {1'b1, dst_leaf, dst_port, 1'b0, tx_seq, din_user2host};
                tx_seq        <= tx_seq + 8'd1;
            end else begin
                dout_host2bft <= '0;
            end
        end
    end

    assign rx_data_vld = din_vld && !din_ctrl;
    assign rx_push_ok  = rx_data_vld && rx_push_rdy;
    assign rx_drop     = rx_data_vld && !rx_push_rdy;

    bft_host_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (rx_data_vld),
        .push_rdy (rx_push_rdy),
        .push_dat (din_payload),
        .pop_rdy  (ack_user2host),
        .head_vld (vld_host2user),
        .head_dat (dout_host2user)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (rx_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef BFT_HOST_SEQ_CHECK_EN
    logic [7:0] rx_seq_exp;
    logic       seq_err_q;

    // Match or mismatch, the next expected value follows the stored packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_seq_exp <= '0;
            seq_err_q  <= 1'b0;
        end else if (rx_push_ok) begin
            if (din_seq != rx_seq_exp) seq_err_q <= 1'b1;
            rx_seq_exp <= din_seq + 8'd1;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_seq;
    assign unused_seq = ^{din_seq, rx_push_ok};
    assign seq_err    = 1'b0;
`endif
endmodule
